fluxo_progresso: RTL and testbench

Parametrised game-progress datapath for the LED-matrix puzzle. It sits between the raw button pins, the matrix block and the top-level control unit. It synchronises and edge-detects a configurable number of buttons, and maintains a saturating level counter with last-level comparison. It adds capabilities the previous datapath lacked: a per-level move counter, a per-level time limit, and a sticky level-completed latch that gates further input.

---
 rtl/jogo_pkg.sv | 11 +
 rtl/sincronizador_borda.sv | 37 +++
 rtl/fluxo_progresso.sv | 113 +++++++++++
 tb/tb_fluxo_progresso.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared game defaults for the control unit, matrix and progress datapath
package jogo_pkg;

  localparam int N_BOTOES_PADRAO     = 8;
  localparam int NIVEL_W_PADRAO      = 3;
  localparam int ULTIMO_NIVEL_PADRAO = 5;
  localparam int JOGADAS_W_PADRAO    = 8;
  localparam int TEMPO_W_PADRAO      = 26;
  localparam int TEMPO_LIMITE_PADRAO = 50_000_000;

endpackage

// File: rtl/sincronizador_borda.sv
// rtl/sincronizador_borda.sv - per-button 2-FF synchroniser, rise detector and gated registered pulse
module sincronizador_borda #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_dado,
  input  logic         i_gate,
  output logic [W-1:0] o_pulso
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;
  logic [W-1:0] r_borda;
  logic [W-1:0] r_pulso;

  // The gate is applied only at the last stage, so a pulse that got through stays through.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta  <= '0;
      r_sync  <= '0;
      r_prev  <= '0;
      r_borda <= '0;
      r_pulso <= '0;
    end else begin
      r_meta  <= i_dado;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_borda <= r_sync & ~r_prev;
      r_pulso <= r_borda & {W{i_gate}};
    end
  end

  assign o_pulso = r_pulso;

endmodule

// File: rtl/fluxo_progresso.sv
// rtl/fluxo_progresso.sv - level counter, move counter, level timer and completion/timeout latches
module fluxo_progresso
  import jogo_pkg::*;
#(
  parameter int N_BOTOES     = N_BOTOES_PADRAO,
  parameter int NIVEL_W      = NIVEL_W_PADRAO,
  parameter int ULTIMO_NIVEL = ULTIMO_NIVEL_PADRAO,
  parameter int JOGADAS_W    = JOGADAS_W_PADRAO,
  parameter int TEMPO_W      = TEMPO_W_PADRAO,
  parameter int TEMPO_LIMITE = TEMPO_LIMITE_PADRAO
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 habilita,
  input  logic                 zeraN,
  input  logic                 contaN,
  input  logic [N_BOTOES-1:0]  botoes,
  input  logic                 nivel_concluido,
  output logic [N_BOTOES-1:0]  botoes_pulso,
  output logic [NIVEL_W-1:0]   nivel,
  output logic [JOGADAS_W-1:0] jogadas,
  output logic                 nivel_ok,
  output logic                 timeout,
  output logic                 fim_jogo,
  output logic                 nivelIgualUltimoNivel,
  output logic                 nivelMenorOuIgualUltimoNivel
);

  localparam logic [NIVEL_W-1:0] ULTIMO      = NIVEL_W'(ULTIMO_NIVEL);
  localparam logic               TEMPO_ATIVO = (TEMPO_LIMITE != 0);
  localparam logic [TEMPO_W-1:0] LIMITE_M1   = TEMPO_ATIVO ? TEMPO_W'(TEMPO_LIMITE - 1) : '0;

  logic [NIVEL_W-1:0]   r_nivel;
  logic [JOGADAS_W-1:0] r_jogadas;
  logic [TEMPO_W-1:0]   r_tempo;
  logic                 r_ok;
  logic                 r_timeout;

  logic w_gate;
  logic w_conta_tempo;
  logic w_expira;
  logic w_limpa;
  logic w_jogada;
  logic w_concluiu;

  assign w_gate        = habilita & ~r_ok & ~r_timeout;
  assign w_conta_tempo = w_gate & TEMPO_ATIVO;
  assign w_expira      = w_conta_tempo & (r_tempo == LIMITE_M1);
  assign w_limpa       = zeraN | contaN;
  assign w_jogada      = |botoes_pulso;
  // Timeout beats a completion arriving on the very same edge.
  assign w_concluiu    = nivel_concluido & habilita & ~r_timeout & ~w_expira;

  sincronizador_borda #(
    .W (N_BOTOES)
  ) u_sincronizador (
    .clock   (clock),
    .reset   (reset),
    .i_dado  (botoes),
    .i_gate  (w_gate),
    .o_pulso (botoes_pulso)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_nivel <= '0;
    end else if (zeraN) begin
      r_nivel <= '0;
    end else if (contaN && (r_nivel < ULTIMO)) begin
      r_nivel <= r_nivel + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_jogadas <= '0;
    end else if (w_limpa) begin
      r_jogadas <= '0;
    end else if (w_jogada && !r_ok && (r_jogadas != '1)) begin
      r_jogadas <= r_jogadas + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tempo   <= '0;
      r_timeout <= 1'b0;
      r_ok      <= 1'b0;
    end else if (w_limpa) begin
      r_tempo   <= '0;
      r_timeout <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      if (w_expira) begin
        r_timeout <= 1'b1;
      end else if (w_conta_tempo) begin
        r_tempo <= r_tempo + 1'b1;
      end
      if (w_concluiu) begin
        r_ok <= 1'b1;
      end
    end
  end

  assign nivel                        = r_nivel;
  assign jogadas                      = r_jogadas;
  assign nivel_ok                     = r_ok;
  assign timeout                      = r_timeout;
  assign nivelIgualUltimoNivel        = (r_nivel == ULTIMO);
  assign nivelMenorOuIgualUltimoNivel = (r_nivel <= ULTIMO);
  assign fim_jogo                     = r_ok & nivelIgualUltimoNivel;

endmodule

// File: tb/tb_fluxo_progresso.sv
// tb/tb_fluxo_progresso.sv - scoreboard bench: timer-disabled instance [0] and 10-cycle-limit instance [1]
module tb_fluxo_progresso;

  localparam int NB = 8;
  localparam int NW = 3;
  localparam int UL = 5;
  localparam int JW = 8;

  typedef struct {
    int          cyc;
    logic [7:0]  val;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic habilita, zeraN, contaN, nivel_concluido;
  logic [NB-1:0] botoes;

  logic [NB-1:0] pul_o [2];
  logic [NW-1:0] niv_o [2];
  logic [JW-1:0] jog_o [2];
  logic          ok_o  [2];
  logic          to_o  [2];
  logic          fim_o [2];
  logic          eq_o  [2];
  logic          le_o  [2];

  always #5 clock = ~clock;

  fluxo_progresso #(.N_BOTOES(NB), .NIVEL_W(NW), .ULTIMO_NIVEL(UL), .JOGADAS_W(JW), .TEMPO_W(26), .TEMPO_LIMITE(0)) dut_a (
    .clock(clock), .reset(reset), .habilita(habilita), .zeraN(zeraN), .contaN(contaN),
    .botoes(botoes), .nivel_concluido(nivel_concluido), .botoes_pulso(pul_o[0]), .nivel(niv_o[0]),
    .jogadas(jog_o[0]), .nivel_ok(ok_o[0]), .timeout(to_o[0]), .fim_jogo(fim_o[0]),
    .nivelIgualUltimoNivel(eq_o[0]), .nivelMenorOuIgualUltimoNivel(le_o[0]));

  fluxo_progresso #(.N_BOTOES(NB), .NIVEL_W(NW), .ULTIMO_NIVEL(UL), .JOGADAS_W(JW), .TEMPO_W(26), .TEMPO_LIMITE(10)) dut_b (
    .clock(clock), .reset(reset), .habilita(habilita), .zeraN(zeraN), .contaN(contaN),
    .botoes(botoes), .nivel_concluido(nivel_concluido), .botoes_pulso(pul_o[1]), .nivel(niv_o[1]),
    .jogadas(jog_o[1]), .nivel_ok(ok_o[1]), .timeout(to_o[1]), .fim_jogo(fim_o[1]),
    .nivelIgualUltimoNivel(eq_o[1]), .nivelMenorOuIgualUltimoNivel(le_o[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: one copy of the game state per instance, button history shared.
  int         lim   [2] = '{0, 10};
  int         m_niv [2];
  int         m_jog [2];
  int         m_tmr [2];
  bit         m_ok  [2];
  bit         m_to  [2];
  logic [7:0] m_pul [2];
  logic [7:0] h     [4];
  exp_t qa[$];
  exp_t qb[$];
  exp_t e_a, e_b, e_n;

  task automatic chk(input string nm, input int idx, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] at cycle %0d: got %0d expected %0d", nm, idx, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_niv[i] = 0; m_jog[i] = 0; m_tmr[i] = 0; m_ok[i] = 0; m_to[i] = 0; m_pul[i] = '0;
    end
    for (int j = 0; j < 4; j++) h[j] = '0;
  endtask

  // A button sampled high at edge k after being low at edge k-1 pulses after edge k+3.
  task automatic model_edge();
    logic [7:0] rise;
    rise = h[2] & ~h[3];
    for (int i = 0; i < 2; i++) begin
      automatic bit clr  = zeraN || contaN;
      automatic bit gate = habilita && !m_ok[i] && !m_to[i];
      automatic bit cnt  = gate && (lim[i] != 0);
      automatic bit expr = cnt && (m_tmr[i] == lim[i] - 1);
      automatic logic [7:0] np = gate ? rise : 8'h00;
      if (clr) m_jog[i] = 0;
      else if (m_pul[i] != 0 && !m_ok[i] && m_jog[i] < 255) m_jog[i]++;
      if (zeraN) m_niv[i] = 0;
      else if (contaN && m_niv[i] < UL) m_niv[i]++;
      if (clr) begin
        m_tmr[i] = 0; m_to[i] = 0; m_ok[i] = 0;
      end else begin
        if (expr) m_to[i] = 1;
        else if (cnt) m_tmr[i]++;
        if (nivel_concluido && habilita && !m_to[i] && !expr) m_ok[i] = 1;
      end
      m_pul[i] = np;
      if (np != 0) begin
        e_n.cyc = cyc; e_n.val = np;
        if (i == 0) qa.push_back(e_n); else qb.push_back(e_n);
      end
    end
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = botoes;
  endtask

  task automatic check_state();
    for (int i = 0; i < 2; i++) begin
      chk("nivel", i, niv_o[i], m_niv[i]);
      chk("jogadas", i, jog_o[i], m_jog[i]);
      chk("nivel_ok", i, ok_o[i], m_ok[i]);
      chk("timeout", i, to_o[i], m_to[i]);
      chk("fim_jogo", i, fim_o[i], (m_ok[i] && m_niv[i] == UL) ? 1 : 0);
      chk("igual_ultimo", i, eq_o[i], (m_niv[i] == UL) ? 1 : 0);
      chk("menor_igual", i, le_o[i], (m_niv[i] <= UL) ? 1 : 0);
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    model_edge();
    @(negedge clock);
    check_state();
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (pul_o[0] != 8'h00) begin
        if (qa.size() == 0) chk("pulse_extra", 0, pul_o[0], 0);
        else begin
          e_a = qa.pop_front();
          chk("pulse_val", 0, pul_o[0], e_a.val);
          chk("pulse_cyc", 0, cyc, e_a.cyc);
        end
      end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
        chk("pulse_miss", 0, 0, qa[0].val);
        qa.delete(0);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (pul_o[1] != 8'h00) begin
        if (qb.size() == 0) chk("pulse_extra", 1, pul_o[1], 0);
        else begin
          e_b = qb.pop_front();
          chk("pulse_val", 1, pul_o[1], e_b.val);
          chk("pulse_cyc", 1, cyc, e_b.cyc);
        end
      end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
        chk("pulse_miss", 1, 0, qb[0].val);
        qb.delete(0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  int jog_save;

  initial begin
    reset = 1'b1; habilita = 1'b0; zeraN = 1'b0; contaN = 1'b0; nivel_concluido = 1'b0; botoes = '0;
    model_reset();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst_pulso", i, pul_o[i], 0);
      chk("rst_nivel", i, niv_o[i], 0);
      chk("rst_jogadas", i, jog_o[i], 0);
      chk("rst_ok", i, ok_o[i], 0);
      chk("rst_timeout", i, to_o[i], 0);
      chk("rst_fim", i, fim_o[i], 0);
      chk("rst_igual", i, eq_o[i], 0);
      chk("rst_menor_igual", i, le_o[i], 1);
    end
    reset = 1'b0;

    // single press held for 100 cycles
    habilita = 1'b1;
    botoes = 8'h08;
    repeat (100) step();
    chk("hold_jogadas", 0, jog_o[0], 1);
    botoes = 8'h00;
    repeat (4) step();

    // simultaneous buttons, then saturation
    for (int n = 0; n < 300; n++) begin
      botoes = 8'h21; step();
      botoes = 8'h00; step();
    end
    repeat (5) step();
    chk("jog_saturado", 0, jog_o[0], 255);

    // level counter saturation and zeraN priority
    for (int n = 0; n < 7; n++) begin
      contaN = 1'b1; step();
      chk("nivel_seq", 0, niv_o[0], (n + 1 < UL) ? n + 1 : UL);
    end
    contaN = 1'b0;
    chk("nivel_igual", 0, eq_o[0], 1);
    zeraN = 1'b1; contaN = 1'b1; step();
    zeraN = 1'b0; contaN = 1'b0;
    chk("zera_prioridade", 0, niv_o[0], 0);

    // 10-cycle timeout on instance 1
    contaN = 1'b1; step(); contaN = 1'b0;
    repeat (9) step();
    chk("timeout_cedo", 1, to_o[1], 0);
    step();
    chk("timeout_setado", 1, to_o[1], 1);
    jog_save = m_jog[1];
    botoes = 8'h02; step(); botoes = 8'h00;
    repeat (5) step();
    chk("timeout_jog", 1, jog_o[1], jog_save);
    nivel_concluido = 1'b1; step(); nivel_concluido = 1'b0;
    chk("timeout_ignora_ok", 1, ok_o[1], 0);
    contaN = 1'b1; step(); contaN = 1'b0;
    chk("conta_limpa_to", 1, to_o[1], 0);
    chk("conta_limpa_jog", 1, jog_o[1], 0);

    // completion at the last level
    zeraN = 1'b1; step(); zeraN = 1'b0;
    contaN = 1'b1; repeat (5) step(); contaN = 1'b0;
    repeat (3) step();
    nivel_concluido = 1'b1; step(); nivel_concluido = 1'b0;
    chk("ok_final", 0, ok_o[0], 1);
    chk("fim_final", 0, fim_o[0], 1);
    jog_save = m_jog[0];
    botoes = 8'h10; step(); botoes = 8'h00;
    repeat (20) step();
    chk("ok_congela_jog", 0, jog_o[0], jog_save);
    chk("ok_congela_tempo", 1, to_o[1], 0);

    // completion coinciding with expiry
    contaN = 1'b1; step(); contaN = 1'b0;
    repeat (9) step();
    nivel_concluido = 1'b1; step(); nivel_concluido = 1'b0;
    chk("coincide_to", 1, to_o[1], 1);
    chk("coincide_ok", 1, ok_o[1], 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      habilita        = ($urandom_range(7) != 0);
      zeraN           = ($urandom_range(39) == 0);
      contaN          = ($urandom_range(9) == 0);
      nivel_concluido = ($urandom_range(15) == 0);
      if ($urandom_range(2) == 0) botoes = botoes ^ (8'h01 << $urandom_range(7));
      step();
    end
    habilita = 1'b1; zeraN = 1'b0; contaN = 1'b0; nivel_concluido = 1'b0; botoes = '0;

    // asynchronous reset in the middle of a level
    zeraN = 1'b1; step(); zeraN = 1'b0;
    contaN = 1'b1; repeat (3) step(); contaN = 1'b0;
    for (int n = 0; n < 12; n++) begin
      botoes = 8'h02; step();
      botoes = 8'h00; step();
    end
    repeat (5) step();
    chk("pre_rst_nivel", 0, niv_o[0], 3);
    chk("pre_rst_jog", 0, jog_o[0], 12);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_nivel", i, niv_o[i], 0);
      chk("async_jogadas", i, jog_o[i], 0);
      chk("async_ok", i, ok_o[i], 0);
      chk("async_timeout", i, to_o[i], 0);
      chk("async_pulso", i, pul_o[i], 0);
      chk("async_menor_igual", i, le_o[i], 1);
    end
    model_reset();
    qa.delete();
    qb.delete();
    @(negedge clock);
    reset = 1'b0;
    botoes = 8'h40; step(); botoes = 8'h00;
    repeat (8) step();

    chk("sobra_fila", 0, qa.size(), 0);
    chk("sobra_fila", 1, qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
